// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the image UART link.
// Synchronizes the raw line, gates the external baud generator via baud_en,
// samples start/data/stop bits on the mid-bit baud_tick and hands each good
// byte to the framebuffer writer as a one-cycle data_valid strobe.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a low level on rx_s
// START  | generator running, confirm start bit at first tick
// DATA   | shift in DATA_BITS samples, LSB first
// PARITY | sample the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit, deliver byte or flag framing error
// BREAK  | bad stop seen, wait for line to return high before re-arming
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd5
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
`endif

  // Input synchronizer; resets to the idle-high line level so no false start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // State, datapath and strobe registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state and datapath updates; strobes default low so they last one cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_tick) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            // glitch shorter than half a bit: silently re-arm
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          // even parity: data bits plus parity bit must XOR to zero
          par_bad_d = rx_s ^ (^shreg_q);
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shreg_q;
            valid_d = 1'b1;
`endif
          end else begin
            state_d = BREAK;
            ferr_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Generator runs only while a frame is being sampled.
  always_comb begin
    baud_en = (state_q == START) || (state_q == DATA) || (state_q == STOP)
`ifdef UART_RX_PARITY_EN
              || (state_q == PARITY)
`endif
              ;
    busy    = (state_q != IDLE);
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: models the paired baud generator, drives
// frames from a vector table plus hand-written corner sequences, and checks
// every strobe against a scoreboard of expected results.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS   = 104;
  localparam int FIRST_TICK = 51;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       baud_tick = 1'b0;
  logic       baud_en;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic       perr_w;

`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  assign perr_w = parity_err;
`else
  assign perr_w = 1'b0;
`endif

  uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .baud_tick  (baud_tick),
    .baud_en    (baud_en),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #42 clk = ~clk;

  // Baud generator model: restarts when baud_en drops, first tick mid start bit.
  int  bg_cnt = 0;
  logic bg_first = 1'b1;
  always @(posedge clk) begin
    if (!baud_en) begin
      bg_cnt    <= 0;
      bg_first  <= 1'b1;
      baud_tick <= 1'b0;
    end else if (bg_cnt == (bg_first ? FIRST_TICK - 1 : BIT_CLKS - 1)) begin
      bg_cnt    <= 0;
      bg_first  <= 1'b0;
      baud_tick <= 1'b1;
    end else begin
      bg_cnt    <= bg_cnt + 1;
      baud_tick <= 1'b0;
    end
  end

  // code bits: {parity_err, frame_err, data_valid}
  typedef struct packed {
    logic [2:0] code;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       stop_b;
    logic       par_flip;
    logic [7:0] gap;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Any strobe pops one scoreboard entry and must match kind and data.
  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t       e;
    obs = {perr_w, frame_err, data_valid};
    if (obs != 3'b000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, obs}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", {29'd0, obs}, {29'd0, e.code});
        check("strobe_data", {24'd0, data}, {24'd0, e.data});
      end
    end
  end

  function automatic exp_t expect_frame(input logic [7:0] d, input logic stop_b,
                                        input logic par_flip, input logic [7:0] prev);
    exp_t e;
    logic perr;
`ifdef UART_RX_PARITY_EN
    perr = par_flip;
`else
    perr = 1'b0 & par_flip;
`endif
    e.code = {perr, ~stop_b, stop_b & ~perr};
    e.data = (stop_b & ~perr) ? d : prev;
    return e;
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  // Push expectation, send, and confirm the strobe was consumed and data settled.
  task automatic do_frame(input string name, input logic [7:0] d, input logic stop_b,
                          input logic par_flip);
    exp_t e;
    e = expect_frame(d, stop_b, par_flip, last_good);
    sb_q.push_back(e);
    send_frame(d, stop_b, par_flip);
    last_good = e.data;
    check({name, "_strobe_seen"}, sb_q.size(), 0);
    check({name, "_data"}, {24'd0, data}, {24'd0, e.data});
  endtask

  vec_t vecs[8];
  int   en_cnt;

  initial begin
    vecs[0] = '{d: 8'hA5, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd20};
    vecs[1] = '{d: 8'h00, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd0};
    vecs[2] = '{d: 8'hFF, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd20};
    vecs[3] = '{d: 8'h3C, stop_b: 1'b0, par_flip: 1'b0, gap: 8'd30};
    vecs[4] = '{d: 8'h5A, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd10};
    vecs[5] = '{d: 8'h81, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd10};
    vecs[6] = '{d: 8'h7E, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd0};
    vecs[7] = '{d: 8'h01, stop_b: 1'b1, par_flip: 1'b0, gap: 8'd15};

    // reset state
    repeat (5) @(negedge clk);
    check("rst_baud_en", {31'd0, baud_en}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_data", {24'd0, data}, 0);
    check("rst_valid", {31'd0, data_valid}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // table of frames, including a back-to-back pair and a bad stop bit
    for (int v = 0; v < 8; v++) begin
      do_frame($sformatf("vec%0d", v), vecs[v].d, vecs[v].stop_b, vecs[v].par_flip);
      rx = 1'b1;
      repeat (int'(vecs[v].gap)) @(negedge clk);
      if (vecs[v].gap >= 8'd4) begin
        check($sformatf("vec%0d_busy", v), {31'd0, busy}, 0);
        check($sformatf("vec%0d_baud_en", v), {31'd0, baud_en}, 0);
      end
    end

    // short low glitch: false start, generator enabled only until first tick
    en_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (baud_en) en_cnt++;
    end
    rx = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (baud_en) en_cnt++;
    end
    check("glitch_en_window", {31'd0, (en_cnt >= 48 && en_cnt <= 56)}, 1);
    check("glitch_busy", {31'd0, busy}, 0);

    // bad stop followed by a long break: one frame_err, data held, no re-trigger
    do_frame("pre_break", 8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    do_frame("break", 8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (2000) @(negedge clk);
    check("break_data_held", {24'd0, data}, 32'hA5);
    check("break_busy", {31'd0, busy}, 1);
    check("break_baud_en", {31'd0, baud_en}, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_exit_busy", {31'd0, busy}, 0);
    do_frame("post_break", 8'h5A, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // reset in the 4th data bit of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst_busy_before", {31'd0, busy}, 1);
    rstn = 1'b0;
    #1;
    check("midrst_baud_en", {31'd0, baud_en}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_data", {24'd0, data}, 0);
    check("midrst_valid", {31'd0, data_valid}, 0);
    check("midrst_ferr", {31'd0, frame_err}, 0);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    do_frame("post_rst", 8'h81, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    do_frame("par_good", 8'h07, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    do_frame("par_bad", 8'h07 ^ 8'h00, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    do_frame("par_bad_stop_bad", 8'h33, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("par_final_busy", {31'd0, busy}, 0);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
